// File: rtl/tetris_vga_render.sv
// Tetris board renderer: VGA timing, bordered board with overlaid planes from a per-frame grid snapshot.
// One pixel of latency from counters to registered sync/colour; outputs change only on pix_en.
module tetris_vga_render #(
  parameter int                   COLS          = 10,
  parameter int                   ROWS          = 20,
  parameter int                   CELL_LOG2     = 4,
  parameter int                   PLANES        = 2,
  parameter logic [8*PLANES-1:0]  PLANE_COLORS  = 16'h671F,
  parameter logic [7:0]           COLOR_OVERLAP = 8'hE0,
  parameter logic [7:0]           COLOR_BORDER  = 8'hFF,
  parameter logic [7:0]           COLOR_BG      = 8'h00,
  parameter int                   BOARD_X       = 240,
  parameter int                   BOARD_Y       = 80,
  parameter int                   BORDER        = 16,
  parameter int                   PIX_DIV       = 4,
  parameter int                   H_ACTIVE      = 640,
  parameter int                   H_FRONT       = 16,
  parameter int                   H_SYNC        = 96,
  parameter int                   H_BACK        = 48,
  parameter int                   V_ACTIVE      = 480,
  parameter int                   V_FRONT       = 10,
  parameter int                   V_SYNC        = 2,
  parameter int                   V_BACK        = 33
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PLANES*ROWS*COLS-1:0] grid,
  output logic                        HSync,
  output logic                        VSync,
  output logic [2:0]                  R,
  output logic [2:0]                  G,
  output logic [1:0]                  B,
  output logic                        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int RC      = ROWS * COLS;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_LO    = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_HI    = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_LO    = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_HI    = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  // Region arithmetic is done at 32 bits so no parameter combination can wrap.
  localparam logic [31:0] BX_LO  = 32'(BOARD_X);
  localparam logic [31:0] BX_HI  = 32'(BOARD_X + COLS * (2 ** CELL_LOG2));
  localparam logic [31:0] BY_LO  = 32'(BOARD_Y);
  localparam logic [31:0] BY_HI  = 32'(BOARD_Y + ROWS * (2 ** CELL_LOG2));
  localparam logic [31:0] BORD   = 32'(BORDER);
  localparam logic [31:0] ROWS_L = 32'(ROWS);
  localparam logic [31:0] COLS_L = 32'(COLS);
  localparam logic [RC-1:0] ONE  = RC'(1);

  logic [DW-1:0]          r_div;
  logic [HW-1:0]          r_h;
  logic [VW-1:0]          r_v;
  logic                   r_hs;
  logic                   r_vs;
  logic [7:0]             r_rgb;
  logic                   r_tick;
  logic [PLANES*RC-1:0]   r_snap;

  logic                   w_pix_en;
  logic                   w_cap;
  logic                   w_active;
  logic [31:0]            w_x;
  logic [31:0]            w_y;
  logic                   w_board;
  logic                   w_frame;
  logic [31:0]            w_col;
  logic [31:0]            w_row;
  logic [31:0]            w_bit;
  logic [PLANES-1:0]      w_hit;
  logic [2:0]             w_cnt;
  logic [7:0]             w_or;
  logic [7:0]             w_color;

  assign w_pix_en = (r_div == DIV_LAST);
  assign w_cap    = w_pix_en && (r_h == '0) && (r_v == V_ACT);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_x      = 32'(r_h);
  assign w_y      = 32'(r_v);

  assign w_board = (w_x >= BX_LO) && (w_x < BX_HI) && (w_y >= BY_LO) && (w_y < BY_HI);
  // Border test adds BORDER on the low side instead of subtracting, so a board at the screen edge never underflows.
  assign w_frame = ((w_x + BORD) >= BX_LO) && (w_x < BX_HI + BORD) &&
                   ((w_y + BORD) >= BY_LO) && (w_y < BY_HI + BORD) && !w_board;

  assign w_col = (w_x - BX_LO) >> CELL_LOG2;
  assign w_row = (w_y - BY_LO) >> CELL_LOG2;
  assign w_bit = (ROWS_L - w_row) * COLS_L - 32'd1 - w_col;

  always_comb begin
    w_hit = '0;
    w_cnt = 3'd0;
    w_or  = 8'h00;
    for (int p = 0; p < PLANES; p++) begin
      w_hit[p] = |((r_snap[p*RC +: RC] >> w_bit) & ONE);
      if (w_hit[p]) begin
        w_cnt = w_cnt + 3'd1;
        w_or  = w_or | PLANE_COLORS[8*p +: 8];
      end
    end
  end

  always_comb begin
    w_color = 8'h00;
    if (w_active) begin
      if (w_board) begin
        if (w_cnt == 3'd0)      w_color = COLOR_BG;
        else if (w_cnt == 3'd1) w_color = w_or;
        else                    w_color = COLOR_OVERLAP;
      end else if (w_frame) begin
        w_color = COLOR_BORDER;
      end else begin
        w_color = COLOR_BG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_h    <= '0;
      r_v    <= '0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_rgb  <= 8'h00;
      r_tick <= 1'b0;
      r_snap <= '0;
    end else begin
      r_tick <= w_cap;
      if (w_pix_en) begin
        r_div <= '0;
        r_hs  <= !((r_h >= HS_LO) && (r_h < HS_HI));
        r_vs  <= !((r_v >= VS_LO) && (r_v < VS_HI));
        r_rgb <= w_color;
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
        end else begin
          r_h <= r_h + HW'(1);
        end
        if (w_cap) r_snap <= grid;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  assign HSync      = r_hs;
  assign VSync      = r_vs;
  assign R          = r_rgb[7:5];
  assign G          = r_rgb[4:2];
  assign B          = r_rgb[1:0];
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_tetris_vga_render.sv
// Directed bench for tetris_vga_render on a shrunken raster (48x30 total, 40x24 active) so whole frames run quickly.
module tb_tetris_vga_render;

  localparam int P    = 2;
  localparam int HTOT = 48;
  localparam int VTOT = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] grid;
  logic        HSync, VSync, frame_tick;
  logic [2:0]  R, G;
  logic [1:0]  B;
  logic [7:0]  rgb;

  assign rgb = {R, G, B};

  tetris_vga_render #(
    .COLS(4), .ROWS(3), .CELL_LOG2(2), .PLANES(3), .PLANE_COLORS(24'h1C671F),
    .BOARD_X(16), .BOARD_Y(8), .BORDER(2), .PIX_DIV(P),
    .H_ACTIVE(40), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(24), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut (
    .clk(clk), .reset(reset), .grid(grid),
    .HSync(HSync), .VSync(VSync), .R(R), .G(G), .B(B), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference raster position: which pixel the registered outputs currently show.
  int m_div, m_h, m_v, o_h, o_v, cyc;
  bit m_vld;
  always @(posedge clk) begin
    if (reset) begin
      m_div <= 0; m_h <= 0; m_v <= 0; m_vld <= 0; o_h <= -1; o_v <= -1; cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_div == P - 1) begin
        m_div <= 0; o_h <= m_h; o_v <= m_v; m_vld <= 1;
        if (m_h == HTOT - 1) begin
          m_h <= 0;
          m_v <= (m_v == VTOT - 1) ? 0 : m_v + 1;
        end else begin
          m_h <= m_h + 1;
        end
      end else begin
        m_div <= m_div + 1;
      end
    end
  end

  typedef struct {
    int         x;
    int         y;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t pre_v[5];
  vec_t main_v[25];
  int   errors = 0;
  int   checks = 0;
  int   t0, t1;

  localparam logic [35:0] G1 = {12'h140, 12'h043, 12'h841};
  localparam logic [35:0] G2 = {12'h000, 12'h800, 12'h000};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_pix(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_vld && o_h == x && o_v == y) && n < 4000);
    if (n >= 4000) chk($sformatf("timeout_pix_%0d_%0d", x, y), 0, 1);
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return HSync;
      1:       return VSync;
      default: return frame_tick;
    endcase
  endfunction

  task automatic wait_lvl(input int sel, input logic val);
    int n = 0;
    while (get_sig(sel) !== val && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) chk($sformatf("timeout_sig%0d", sel), 0, 1);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    wait_pix(v.x, v.y);
    chk($sformatf("%s_rgb_%0d_%0d", tag, v.x, v.y), int'(rgb), int'(v.rgb));
    chk($sformatf("%s_hs_%0d_%0d", tag, v.x, v.y), int'(HSync), int'(v.hs));
    chk($sformatf("%s_vs_%0d_%0d", tag, v.x, v.y), int'(VSync), int'(v.vs));
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] exp, input string nm);
    wait_pix(x, y);
    chk(nm, int'(rgb), int'(exp));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, int'(HSync), 1);
    chk({tag, "_vsync"}, int'(VSync), 1);
    chk({tag, "_rgb"}, int'(rgb), 0);
    chk({tag, "_tick"}, int'(frame_tick), 0);
  endtask

  initial begin
    // Snapshot still all-zero: board is background, frame is drawn.
    pre_v[0] = '{14, 6, 8'hFF, 1'b1, 1'b1};
    pre_v[1] = '{16, 8, 8'h00, 1'b1, 1'b1};
    pre_v[2] = '{20, 12, 8'h00, 1'b1, 1'b1};
    pre_v[3] = '{28, 16, 8'h00, 1'b1, 1'b1};
    pre_v[4] = '{33, 21, 8'hFF, 1'b1, 1'b1};
    // Frame showing G1, in raster order.
    main_v[0]  = '{0, 0, 8'h00, 1'b1, 1'b1};
    main_v[1]  = '{41, 5, 8'h00, 1'b1, 1'b1};
    main_v[2]  = '{42, 5, 8'h00, 1'b0, 1'b1};
    main_v[3]  = '{45, 5, 8'h00, 1'b0, 1'b1};
    main_v[4]  = '{46, 5, 8'h00, 1'b1, 1'b1};
    main_v[5]  = '{15, 6, 8'hFF, 1'b1, 1'b1};
    main_v[6]  = '{14, 8, 8'hFF, 1'b1, 1'b1};
    main_v[7]  = '{16, 8, 8'h1F, 1'b1, 1'b1};
    main_v[8]  = '{20, 8, 8'h00, 1'b1, 1'b1};
    main_v[9]  = '{28, 8, 8'h1C, 1'b1, 1'b1};
    main_v[10] = '{19, 11, 8'h1F, 1'b1, 1'b1};
    main_v[11] = '{31, 11, 8'h1C, 1'b1, 1'b1};
    main_v[12] = '{33, 11, 8'hFF, 1'b1, 1'b1};
    main_v[13] = '{34, 11, 8'h00, 1'b1, 1'b1};
    main_v[14] = '{20, 12, 8'hE0, 1'b1, 1'b1};
    main_v[15] = '{24, 16, 8'h67, 1'b1, 1'b1};
    main_v[16] = '{28, 16, 8'hE0, 1'b1, 1'b1};
    main_v[17] = '{31, 19, 8'hE0, 1'b1, 1'b1};
    main_v[18] = '{16, 20, 8'hFF, 1'b1, 1'b1};
    main_v[19] = '{33, 21, 8'hFF, 1'b1, 1'b1};
    main_v[20] = '{16, 22, 8'h00, 1'b1, 1'b1};
    main_v[21] = '{39, 23, 8'h00, 1'b1, 1'b1};
    main_v[22] = '{40, 23, 8'h00, 1'b1, 1'b1};
    main_v[23] = '{0, 26, 8'h00, 1'b1, 1'b0};
    main_v[24] = '{0, 28, 8'h00, 1'b1, 1'b1};

    reset = 1'b1;
    grid  = G1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;

    foreach (pre_v[i]) apply_vec(pre_v[i], "pre");

    wait_lvl(0, 1'b1);
    wait_lvl(0, 1'b0);
    t0 = cyc;
    wait_lvl(0, 1'b1);
    chk("hsync_low_clk", cyc - t0, 4 * P);
    wait_lvl(0, 1'b0);
    chk("hsync_period_clk", cyc - t0, HTOT * P);

    wait_lvl(2, 1'b1);
    chk("first_tick_clk", cyc, (24 * HTOT + 1) * P);
    t1 = cyc;
    @(negedge clk);
    chk("tick_width", int'(frame_tick), 0);

    wait_lvl(1, 1'b0);
    t0 = cyc;
    wait_lvl(1, 1'b1);
    chk("vsync_low_clk", cyc - t0, 2 * HTOT * P);

    wait_lvl(2, 1'b1);
    chk("frame_period_clk", cyc - t1, HTOT * VTOT * P);

    foreach (main_v[i]) apply_vec(main_v[i], "main");

    // Grid change mid-frame is invisible until the next capture.
    wait_pix(0, 4);
    grid = G2;
    pix(16, 8, 8'h1F, "hold_cell00");
    pix(20, 12, 8'hE0, "hold_cell11");
    wait_lvl(2, 1'b1);
    @(negedge clk);
    chk("tick_width2", int'(frame_tick), 0);
    pix(16, 8, 8'h67, "new_cell00");
    pix(20, 12, 8'h00, "new_cell11");

    // Reset during sync pulses, then a full restart with a blank board.
    wait_pix(43, 26);
    chk("pre_rst_hsync", int'(HSync), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midrst");
    reset = 1'b0;
    pix(14, 6, 8'hFF, "post_rst_border");
    pix(16, 8, 8'h00, "post_rst_blank");
    wait_lvl(2, 1'b1);
    chk("post_rst_tick_clk", cyc, (24 * HTOT + 1) * P);
    pix(16, 8, 8'h67, "post_rst_recapture");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tetris_vga_render.md
TETRIS_VGA_RENDER -- requirements
Module: tetris_vga_render

Interface
REQ-001 SHALL provide parameter COLS, default 10, board columns (1-32).
REQ-002 SHALL provide parameter ROWS, default 20, board rows (1-30).
REQ-003 SHALL provide parameter CELL_LOG2, default 4, cell edge = 2^CELL_LOG2 pixels.
REQ-004 SHALL provide parameter PLANES, default 2, number of overlaid grid layers (1-4).
REQ-005 SHALL provide parameter PLANE_COLORS, default 16'h671F, 8 bits RRRGGGBB per plane, plane 0 in LSBs.
REQ-006 SHALL provide parameter COLOR_OVERLAP, default 8'hE0, used where two or more planes are set.
REQ-007 SHALL provide parameter COLOR_BORDER, default 8'hFF; COLOR_BG, default 8'h00.
REQ-008 SHALL provide parameters BOARD_X, default 240, and BOARD_Y, default 80, active-area pixel of the top-left cell; BORDER, default 16, frame thickness in pixels.
REQ-009 SHALL provide parameter PIX_DIV, default 4, clk cycles per pixel (>=1).
REQ-010 clk  input  1  system clock; one clock; all logic on rising edge.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 grid  input  PLANES*ROWS*COLS  plane p at [p*ROWS*COLS +: ROWS*COLS]; cell (r,c), r=0 top, c=0 left, at in-plane bit (ROWS-r)*COLS-1-c.
REQ-013 HSync, VSync  output  1 each  active-low syncs, registered.
REQ-014 R  output  3;  G  output  3;  B  output  2  registered colour.
REQ-015 frame_tick  output  1  one-clk pulse when grid is sampled.

Function
REQ-016 Internal divider SHALL count 0..PIX_DIV-1 and assert pix_en for one clk when at PIX_DIV-1; no derived clocks.
REQ-017 On pix_en, h SHALL count 0..799 and wrap; v SHALL increment when h wraps, counting 0..524 and wrapping.
REQ-018 Timing SHALL be 640x480: active h<640, v<480; HSync low for h in 656..751; VSync low for v in 490..491.
REQ-019 Outputs SHALL update only on pix_en, reflecting the pre-increment (h,v): one pixel of latency, syncs and colour aligned.
REQ-020 Outside the active area RGB SHALL be 8'h00.
REQ-021 Board region: x in [BOARD_X, BOARD_X+COLS*2^CELL_LOG2), y in [BOARD_Y, BOARD_Y+ROWS*2^CELL_LOG2); cell index = (x-BOARD_X)>>CELL_LOG2, (y-BOARD_Y)>>CELL_LOG2.
REQ-022 Border region: within BORDER pixels outside the board rectangle on any side (corners included) -> COLOR_BORDER.
REQ-023 Board pixel colour from snapshot: zero planes set -> COLOR_BG; exactly one plane p -> PLANE_COLORS[8p+:8]; two or more -> COLOR_OVERLAP.
REQ-024 All other active pixels -> COLOR_BG.
REQ-025 Snapshot SHALL capture all grid bits on the pix_en cycle with h=0, v=480; frame_tick SHALL be high that same clk only.
REQ-026 The snapshot SHALL be constant from v=0 through v=479, so one frame never mixes two grid states.
REQ-027 Changes on grid at any other time SHALL have no visible effect until the next capture.
REQ-028 Counter, region and cell-index arithmetic SHALL be sized with no truncation for the largest legal parameters.

Reset
REQ-029 While reset is high on a clk edge: divider, h, v <= 0; HSync, VSync <= 1; R, G, B <= 0; frame_tick <= 0; snapshot <= all zeros.
REQ-030 Reset mid-frame SHALL abort the frame; first pix_en after release is in the divider's PIX_DIV-th clk, starting at h=0, v=0.
REQ-031 Until the first capture after reset, the board SHALL render as COLOR_BG with border drawn.

Verification
REQ-032 Reset, run 2 frames, PIX_DIV=4 -> HSync low 96 pixels (384 clk), period 3200 clk; VSync low 2 lines; frame period 1,680,000 clk.
REQ-033 grid plane0 bit 199 = 1, rest 0, after capture -> pixels x 240..255, y 80..95 = 8'h1F; x=256, y=80 = 8'h00; x=230, y=90 = 8'hFF.
REQ-034 Plane0 and plane1 both set at cell (19,9) -> x 384..399, y 384..399 = 8'hE0; plane1 only -> 8'h67.
REQ-035 Toggle grid at v=200 of a frame -> current frame unchanged; change appears next frame; frame_tick one clk wide at h=0, v=480.
REQ-036 Assert reset at v=300 for 3 clk -> all outputs at reset values, counters restart at h=0, v=0, board blank.
REQ-037 PLANES=3, COLS=12, ROWS=16, CELL_LOG2=3, PIX_DIV=1 -> cell (0,11) plane2 drawn at x 328..335, y 80..87 in PLANE_COLORS[23:16].
